// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the accumulator calculator.
//   - funct codes FN_NOP..FN_CLR (3-bit field at the top of the instruction)
//   - FSM state encoding (ST_IDLE, ST_MUL)
//   - helper to size iteration counters
package calc_pkg;

   localparam int unsigned FUNCT_W = 3;

   localparam logic [FUNCT_W-1:0] FN_NOP    = 3'b000;
   localparam logic [FUNCT_W-1:0] FN_ADD    = 3'b001;
   localparam logic [FUNCT_W-1:0] FN_SUB    = 3'b010;
   localparam logic [FUNCT_W-1:0] FN_ADDACC = 3'b011;
   localparam logic [FUNCT_W-1:0] FN_SUBACC = 3'b100;
   localparam logic [FUNCT_W-1:0] FN_MUL    = 3'b101;
   localparam logic [FUNCT_W-1:0] FN_MULACC = 3'b110;
   localparam logic [FUNCT_W-1:0] FN_CLR    = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seq_shift_mult.sv
// seq_shift_mult: iterative shift-add multiplier, one multiplier bit per clock, LSB first.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset (aborts any op in flight)
//   i_start          load operands and begin (ignored flags are not needed: caller gates it)
//   i_mcand          WIDTH-bit multiplicand
//   i_mplier         IMM_W-bit multiplier
//   o_done           high in the cycle whose rising edge processes the last multiplier bit
//   o_product        full WIDTH+IMM_W product, valid while o_done is high
module seq_shift_mult
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IMM_W = 14
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic [WIDTH-1:0]       i_mcand,
   input  logic [IMM_W-1:0]       i_mplier,
   output logic                   o_done,
   output logic [WIDTH+IMM_W-1:0] o_product
);

   localparam int unsigned PW    = WIDTH + IMM_W;
   localparam int unsigned CNT_W = cnt_w(IMM_W);

   logic             r_active;
   logic [CNT_W-1:0] r_cnt;
   logic [PW-1:0]    r_prod;
   logic [PW-1:0]    r_mcand;
   logic [IMM_W-1:0] r_mplier;
   logic [PW-1:0]    w_prod_nxt;
   logic             w_last;

   // r_mcand is shifted at most IMM_W-1 places, so the PW-bit register never drops a set bit.
   assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
   assign w_last     = r_active && (r_cnt == CNT_W'(IMM_W - 1));
   assign o_done     = w_last;
   assign o_product  = w_prod_nxt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_active <= 1'b0;
         r_cnt    <= '0;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_cnt    <= '0;
         r_prod   <= '0;
         r_mcand  <= PW'(i_mcand);
         r_mplier <= i_mplier;
      end else if (r_active) begin
         r_prod   <= w_prod_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         if (w_last) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/calc_accum_seq.sv
// calc_accum_seq: accumulator calculator with valid/ready instruction input.
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_instr_valid     i_instr holds a valid instruction
//   o_instr_ready     block accepts an instruction this cycle (idle)
//   i_instr           {funct[2:0], immA[IMM_W-1:0], immB[IMM_W-1:0]}
//   o_acc             accumulator
//   o_result_valid    one-cycle pulse after a completed op updates o_acc
//   o_ovf             carry / borrow / product overflow of the last completed op
//   o_busy            multiply in progress
module calc_accum_seq
   import calc_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned IMM_W   = 14,
   parameter int unsigned INSTR_W = 3 + 2 * IMM_W
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_instr_valid,
   output logic               o_instr_ready,
   input  logic [INSTR_W-1:0] i_instr,
   output logic [WIDTH-1:0]   o_acc,
   output logic               o_result_valid,
   output logic               o_ovf,
   output logic               o_busy
);

   state_t             r_state;
   logic [WIDTH-1:0]   r_acc;
   logic               r_ovf;
   logic               r_result_valid;

   logic [FUNCT_W-1:0] w_funct;
   logic [WIDTH-1:0]   w_imm_a;
   logic [WIDTH-1:0]   w_imm_b;
   logic               w_accept;
   logic               w_is_mul;
   logic [WIDTH:0]     w_add_ab;
   logic [WIDTH:0]     w_sub_ab;
   logic [WIDTH:0]     w_add_acc;
   logic [WIDTH:0]     w_sub_acc;
   logic               w_mult_done;
   logic [WIDTH+IMM_W-1:0] w_mult_prod;
   logic [WIDTH-1:0]   w_mcand;
   logic [IMM_W-1:0]   w_mplier;

   assign w_funct = i_instr[INSTR_W-1 -: FUNCT_W];
   assign w_imm_a = WIDTH'(i_instr[2*IMM_W-1:IMM_W]);
   assign w_imm_b = WIDTH'(i_instr[IMM_W-1:0]);

   assign w_accept = i_instr_valid && (r_state == ST_IDLE);
   assign w_is_mul = (w_funct == FN_MUL) || (w_funct == FN_MULACC);

   // Top bit of each WIDTH+1 result is the carry (add) or borrow (sub).
   assign w_add_ab  = {1'b0, w_imm_a} + {1'b0, w_imm_b};
   assign w_sub_ab  = {1'b0, w_imm_a} - {1'b0, w_imm_b};
   assign w_add_acc = {1'b0, r_acc} + {1'b0, w_imm_a};
   assign w_sub_acc = {1'b0, r_acc} - {1'b0, w_imm_a};

   assign w_mcand  = (w_funct == FN_MUL) ? w_imm_a : r_acc;
   assign w_mplier = (w_funct == FN_MUL) ? i_instr[IMM_W-1:0] : i_instr[2*IMM_W-1:IMM_W];

   seq_shift_mult #(
      .WIDTH (WIDTH),
      .IMM_W (IMM_W)
   ) u_mult (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_start   (w_accept && w_is_mul),
      .i_mcand   (w_mcand),
      .i_mplier  (w_mplier),
      .o_done    (w_mult_done),
      .o_product (w_mult_prod)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= ST_IDLE;
         r_acc          <= '0;
         r_ovf          <= 1'b0;
         r_result_valid <= 1'b0;
      end else begin
         r_result_valid <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  case (w_funct)
                     FN_ADD: begin
                        {r_ovf, r_acc} <= w_add_ab;
                        r_result_valid <= 1'b1;
                     end
                     FN_SUB: begin
                        {r_ovf, r_acc} <= w_sub_ab;
                        r_result_valid <= 1'b1;
                     end
                     FN_ADDACC: begin
                        {r_ovf, r_acc} <= w_add_acc;
                        r_result_valid <= 1'b1;
                     end
                     FN_SUBACC: begin
                        {r_ovf, r_acc} <= w_sub_acc;
                        r_result_valid <= 1'b1;
                     end
                     FN_MUL, FN_MULACC: begin
                        r_state <= ST_MUL;
                     end
                     FN_CLR: begin
                        r_acc          <= '0;
                        r_ovf          <= 1'b0;
                        r_result_valid <= 1'b1;
                     end
                     default: ; // FN_NOP
                  endcase
               end
            end
            ST_MUL: begin
               if (w_mult_done) begin
                  r_acc          <= w_mult_prod[WIDTH-1:0];
                  r_ovf          <= |w_mult_prod[WIDTH+IMM_W-1:WIDTH];
                  r_result_valid <= 1'b1;
                  r_state        <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_acc          = r_acc;
   assign o_ovf          = r_ovf;
   assign o_result_valid = r_result_valid;
   assign o_busy         = (r_state == ST_MUL);
   assign o_instr_ready  = (r_state == ST_IDLE);

endmodule

// File: tb/tb_calc_accum_seq.sv
// Scoreboard bench for calc_accum_seq: stimulus pushes expected {acc, ovf}, a negedge monitor
// pops and compares on every result_valid pulse.
module tb_calc_accum_seq;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned IMM_W   = 14;
   localparam int unsigned INSTR_W = 3 + 2 * IMM_W;

   localparam logic [2:0] NOP = 3'b000, ADD = 3'b001, SUB = 3'b010, ADDACC = 3'b011;
   localparam logic [2:0] SUBACC = 3'b100, MUL = 3'b101, MULACC = 3'b110, CLR = 3'b111;

   logic               clk = 1'b0;
   logic               reset;
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr;
   logic [WIDTH-1:0]   acc;
   logic               result_valid;
   logic               ovf;
   logic               busy;

   typedef struct packed {
      logic [WIDTH-1:0] acc;
      logic             ovf;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   run_len = 0;
   int   max_run = 0;

   always #5 clk = ~clk;

   calc_accum_seq #(
      .WIDTH   (WIDTH),
      .IMM_W   (IMM_W),
      .INSTR_W (INSTR_W)
   ) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_instr_valid  (instr_valid),
      .o_instr_ready  (instr_ready),
      .i_instr        (instr),
      .o_acc          (acc),
      .o_result_valid (result_valid),
      .o_ovf          (ovf),
      .o_busy         (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every result pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && result_valid) begin
         run_len++;
         if (run_len > max_run) max_run = run_len;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got acc=0x%0h ovf=%0b, expected no result", acc, ovf);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result_acc", 64'(acc), 64'(e.acc));
            chk("result_ovf", 64'(ovf), 64'(e.ovf));
         end
      end else begin
         run_len = 0;
      end
   end

   // Present an instruction and hold it until accepted at a rising edge.
   task automatic send(input logic [2:0] f, input logic [IMM_W-1:0] a,
                       input logic [IMM_W-1:0] b, input bit push,
                       input logic [WIDTH-1:0] e_acc, input logic e_ovf);
      int n;
      exp_t e;
      @(negedge clk);
      instr_valid = 1'b1;
      instr       = {f, a, b};
      n = 0;
      while (!instr_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: got ready=0, expected ready=1 within 200 cycles");
      end
      if (push) begin
         e.acc = e_acc;
         e.ovf = e_ovf;
         exp_q.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      reset       = 1'b1;
      instr_valid = 1'b0;
      instr       = '0;
      repeat (3) @(negedge clk);
      chk("reset_acc", 64'(acc), 64'd0);
      chk("reset_ovf", 64'(ovf), 64'd0);
      chk("reset_rv", 64'(result_valid), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_ready", 64'(instr_ready), 64'd1);
      reset = 1'b0;

      // ADD then NOP.
      send(ADD, 14'd5, 14'd7, 1'b1, 32'd12, 1'b0);
      send(NOP, 14'd0, 14'd0, 1'b0, 32'd0, 1'b0);
      idle(3);
      chk("nop_keeps_acc", 64'(acc), 64'd12);

      // SUB borrow, ADDACC carry, CLR.
      send(SUB, 14'd3, 14'd5, 1'b1, 32'hFFFF_FFFE, 1'b1);
      send(ADDACC, 14'd2, 14'd0, 1'b1, 32'd0, 1'b1);
      send(CLR, 14'd0, 14'd0, 1'b1, 32'd0, 1'b0);
      idle(3);

      // MUL with a following ADD held valid throughout the multiply.
      send(MUL, 14'd100, 14'd200, 1'b1, 32'd20000, 1'b0);
      @(negedge clk);
      instr = {ADD, 14'd1, 14'd2};
      cnt = 0;
      while (!instr_ready && cnt < 100) begin
         if (busy) cnt++;
         @(negedge clk);
      end
      chk("mul_busy_cycles", 64'(cnt), 64'd14);
      chk("mul_done_acc", 64'(acc), 64'd20000);
      begin
         exp_t e;
         e.acc = 32'd3;
         e.ovf = 1'b0;
         exp_q.push_back(e);
      end
      @(posedge clk);
      idle(3);

      // Build 0x40000000 then overflow it with MULACC 4.
      send(ADD, 14'd1, 14'd0, 1'b1, 32'd1, 1'b0);
      send(MULACC, 14'd8192, 14'd0, 1'b1, 32'h0000_2000, 1'b0);
      send(MULACC, 14'd8192, 14'd0, 1'b1, 32'h0400_0000, 1'b0);
      send(MULACC, 14'd16, 14'd0, 1'b1, 32'h4000_0000, 1'b0);
      send(MULACC, 14'd4, 14'd0, 1'b1, 32'd0, 1'b1);
      send(ADD, 14'd5, 14'd0, 1'b1, 32'd5, 1'b0);
      send(MULACC, 14'd3, 14'd0, 1'b1, 32'd15, 1'b0);
      idle(20);
      chk("queue_drained_pre_abort", 64'(exp_q.size()), 64'd0);

      // Reset on the 5th multiply cycle aborts with no result.
      send(MUL, 14'd100, 14'd200, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_acc", 64'(acc), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_ready", 64'(instr_ready), 64'd1);
      chk("abort_rv", 64'(result_valid), 64'd0);
      reset = 1'b0;
      idle(20);

      // Back-to-back single-cycle ops: three results on consecutive cycles.
      max_run = 0;
      send(ADD, 14'd10, 14'd20, 1'b1, 32'd30, 1'b0);
      send(ADDACC, 14'd5, 14'd0, 1'b1, 32'd35, 1'b0);
      send(SUBACC, 14'd40, 14'd0, 1'b1, 32'hFFFF_FFFB, 1'b1);
      idle(3);
      chk("b2b_run", 64'(max_run), 64'd3);

      idle(5);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
